// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared MDop encodings and timing helpers for the multiply/
//               divide unit and the decode logic that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [3:0] c_MD_NONE  = 4'd0;
    localparam logic [3:0] c_MD_MULT  = 4'd1;
    localparam logic [3:0] c_MD_MULTU = 4'd2;
    localparam logic [3:0] c_MD_DIV   = 4'd3;
    localparam logic [3:0] c_MD_DIVU  = 4'd4;
    localparam logic [3:0] c_MD_MTHI  = 4'd5;
    localparam logic [3:0] c_MD_MTLO  = 4'd6;
    localparam logic [3:0] c_MD_MFHI  = 4'd7;
    localparam logic [3:0] c_MD_MFLO  = 4'd8;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op == c_MD_MULT) || (op == c_MD_MULTU) ||
               (op == c_MD_DIV)  || (op == c_MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : EX-stage multiply/divide unit with private HI/LO registers.
//               Results are computed at the Start edge into pending
//               registers; a down-counter models the multicycle latency and
//               commits them to HI/LO when it expires.
// Ports       : clk, reset (sync, active-high)
//               A, B     - forwarded rs/rt operands
//               MDop     - operation code, MDEn - EX instruction valid
//               Start    - multicycle op being issued this cycle (comb)
//               Busy     - operation in progress (registered)
//               HI, LO   - architectural HI/LO registers
//               MDout    - mfhi/mflo read data (comb), 0 otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDop,
    input  logic        MDEn,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW   = $clog2(c_MAXC + 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_busy;
    logic [31:0]     r_hi, r_lo, r_phi, r_plo;

    logic signed [63:0] w_sprod;
    logic [63:0]        w_uprod;
    logic [31:0]        w_abs_a, w_abs_b, w_sq, w_sr, w_uq, w_ur, w_divisor;
    logic [31:0]        w_res_hi, w_res_lo;
    logic               w_b_zero;

    assign Start = MDEn && is_start_op(MDop);

    // Products on sign- or zero-extended operands so the full 64 bits are exact.
    assign w_sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_uprod = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced so the dividers never see /0; the result is
    // then discarded in favour of the current HI/LO.
    assign w_b_zero  = (B == 32'd0);
    assign w_divisor = w_b_zero ? 32'd1 : B;
    assign w_uq      = A / w_divisor;
    assign w_ur      = A % w_divisor;

    // Signed division on magnitudes: quotient truncates toward zero, the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps back to
    // 0x80000000 with remainder 0 without any special case.
    assign w_abs_a = A[31] ? (32'd0 - A) : A;
    assign w_abs_b = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
    always_comb begin
        logic [31:0] v_q, v_r;
        v_q  = w_abs_a / w_abs_b;
        v_r  = w_abs_a % w_abs_b;
        w_sq = (A[31] ^ w_divisor[31]) ? (32'd0 - v_q) : v_q;
        w_sr = A[31] ? (32'd0 - v_r) : v_r;
    end

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (MDop)
            c_MD_MULT:  begin w_res_hi = w_sprod[63:32]; w_res_lo = w_sprod[31:0]; end
            c_MD_MULTU: begin w_res_hi = w_uprod[63:32]; w_res_lo = w_uprod[31:0]; end
            c_MD_DIV:   if (!w_b_zero) begin w_res_hi = w_sr; w_res_lo = w_sq; end
            c_MD_DIVU:  if (!w_b_zero) begin w_res_hi = w_ur; w_res_lo = w_uq; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
        end else if (r_busy) begin
            // Any MD op arriving now is ignored; hazard logic must stall it.
            if (r_cnt == c_CW'(1)) begin
                r_hi   <= r_phi;
                r_lo   <= r_plo;
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end else if (MDEn) begin
            if (Start) begin
                r_phi  <= w_res_hi;
                r_plo  <= w_res_lo;
                r_busy <= 1'b1;
                r_cnt  <= ((MDop == c_MD_MULT) || (MDop == c_MD_MULTU))
                          ? c_CW'(MULT_CYCLES) : c_CW'(DIV_CYCLES);
            end else if (MDop == c_MD_MTHI) begin
                r_hi <= A;
            end else if (MDop == c_MD_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Read path deliberately ignores MDEn; it is only consumed when valid.
    always_comb begin
        MDout = 32'd0;
        if (MDop == c_MD_MFHI)      MDout = r_hi;
        else if (MDop == c_MD_MFLO) MDout = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for mdu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDop;
    logic        MDEn;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDout;

    int n_vec = 0;
    int n_bad = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDop  (MDop),
        .MDEn  (MDEn),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDout (MDout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multicycle op and verify Busy is high for exactly n cycles.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n);
        A = a; B = b; MDop = op; MDEn = 1'b1;
        #1;
        check({tag, "_start"}, {31'd0, Start}, 32'd1);
        step();
        MDEn = 1'b0; MDop = c_MD_NONE;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            step();
        end
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        MDEn = 1'b1; MDop = c_MD_MFHI; #1;
        check({tag, "_mfhi"}, MDout, eh);
        MDop = c_MD_MFLO; #1;
        check({tag, "_mflo"}, MDout, el);
        check({tag, "_hi"}, HI, eh);
        check({tag, "_lo"}, LO, el);
        MDEn = 1'b0; MDop = c_MD_NONE;
    endtask

    initial begin
        reset = 1'b1; A = '0; B = '0; MDop = c_MD_NONE; MDEn = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        read_hilo("rst", 32'h0, 32'h0);

        run_op("mult", c_MD_MULT, 32'hFFFFFFFF, 32'd2, 5);
        read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

        run_op("multu", c_MD_MULTU, 32'hFFFFFFFF, 32'd2, 5);
        read_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

        run_op("div", c_MD_DIV, 32'hFFFFFFF9, 32'd2, 10);
        read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_op("divu", c_MD_DIVU, 32'd7, 32'd2, 10);
        read_hilo("divu", 32'd1, 32'd3);

        // mthi/mtlo, then divide by zero leaves them untouched
        MDEn = 1'b1; MDop = c_MD_MTHI; A = 32'h12345678; step();
        MDop = c_MD_MTLO; A = 32'h9ABCDEF0; step();
        MDEn = 1'b0; MDop = c_MD_NONE;
        read_hilo("mtx", 32'h12345678, 32'h9ABCDEF0);
        run_op("divz", c_MD_DIVU, 32'd55, 32'd0, 10);
        read_hilo("divz", 32'h12345678, 32'h9ABCDEF0);

        run_op("divovf", c_MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
        read_hilo("divovf", 32'h00000000, 32'h80000000);

        // Reset mid-divide: nothing may land at the original completion time
        A = 32'd100; B = 32'd7; MDop = c_MD_DIV; MDEn = 1'b1;
        step();
        MDEn = 1'b0; MDop = c_MD_NONE;
        step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        check("rstmid_busy", {31'd0, Busy}, 32'd0);
        read_hilo("rstmid", 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        check("rstmid_late_busy", {31'd0, Busy}, 32'd0);
        read_hilo("rstmid_late", 32'h0, 32'h0);

        // mthi while busy must be dropped
        A = 32'h00010000; B = 32'h00030000; MDop = c_MD_MULT; MDEn = 1'b1;
        step();
        MDEn = 1'b0; MDop = c_MD_NONE;
        step();
        MDEn = 1'b1; MDop = c_MD_MTHI; A = 32'hDEADBEEF;
        step();
        MDEn = 1'b0; MDop = c_MD_NONE;
        check("mthibusy_hi", HI, 32'h0);
        step(); step(); step();
        check("mthibusy_done", {31'd0, Busy}, 32'd0);
        read_hilo("mthibusy", 32'h00000003, 32'h00000000);

        // MDEn=0 with a start opcode: no Start, no state change, MDout decodes
        A = 32'd9; B = 32'd9; MDop = c_MD_MULT; MDEn = 1'b0; #1;
        check("noen_start", {31'd0, Start}, 32'd0);
        step();
        check("noen_busy", {31'd0, Busy}, 32'd0);
        MDop = c_MD_MFHI; #1;
        check("noen_mfhi", MDout, 32'h00000003);
        MDop = c_MD_MTLO; A = 32'h55555555; step();
        check("noen_lo", LO, 32'h0);

        // Reset in the same cycle as Start
        A = 32'd3; B = 32'd3; MDop = c_MD_MULT; MDEn = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; MDEn = 1'b0; MDop = c_MD_NONE;
        check("rststart_busy", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        read_hilo("rststart", 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
